pool_ctl_seq: RTL
=================

Name: pool_ctl_seq

Overview:
- Sequencer that drives the 4-bit control word (write, useUpper, useCurrent, useLower) of a column of D max-pooling ALUs.
- Accepts one feature-map column per valid/ready beat from the line buffer.
- Generates per-unit vertical-window control, tracks horizontal window position, and holds a pooled-column valid until downstream accepts it.
- Sits between the input buffer controller and the pooling ALU column and output writer.

Parameters:
- depth, 2, log2 of the number of ALU units in the column.
- D, 1<<depth, number of ALU units.
- CW, 8, width of the frame column counter.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RSTn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg and begins a frame. Ignored unless IDLE.
- cfg_k  in  2  window size; 2 or 3. Any other value is treated as 2.
- cfg_cols  in  CW  frame width in columns.
- in_valid  in  1  input column present on the ALU ip bus.
- in_ready  out  1  sequencer accepts the column this cycle.
- ctl  out  4*D  unit i control at bits [4i+3:4i], ordered {write, useUpper, useCurrent, useLower}.
- acc_first  out  1  accepted beat is the first column of a horizontal window.
- out_valid  out  1  pooled column complete in the ALU max registers.
- out_ready  in  1  downstream consumed the pooled column.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the frame finishes.

Behaviour:
- Reset (async, RSTn=0): state=IDLE; all counters 0; latched cfg reset to k=2, cols=0. Outputs: in_ready=0, out_valid=0, done=0, busy=0, ctl=0, acc_first=0.
- Reset mid-frame aborts immediately. No done pulse is produced.
- States:
  - IDLE: start → RUN, or → FLUSH if cfg_cols < k. Latch k and cols; clear col_cnt and win_col.
  - RUN: in_ready=1. On each accept (in_valid&in_ready), col_cnt and win_col increment.
    - win_col==k-1 accepted → HOLD, win_col=0.
  - HOLD: in_ready=0, out_valid=1 (registered, asserted the cycle after the last window column is accepted).
    - On out_ready, next state is:
      - col_cnt==cols → IDLE with done=1 for one cycle;
      - cols-col_cnt < k → FLUSH;
      - otherwise → RUN.
  - FLUSH: in_ready=1; trailing columns are accepted with ctl=0 and no output. col_cnt==cols → IDLE with done pulse; the pulse is also issued when FLUSH is entered with nothing left.
- ctl is combinational from the registered state, latched k and in_valid. It is all-zero unless a beat is accepted in RUN. The ALUs sample on negedge, so ctl settles within half a cycle.
- Per-unit word on an accepted RUN beat:
  - k=2: unit i active iff i even and i+1<D. Active word = 1011 (write, current, lower).
  - k=3: unit i active iff i%3==1 and i+1<D. Active word = 1111.
  - Inactive units = 0000.
- acc_first = accepted RUN beat with win_col==0.
- Simultaneous events:
  - start while busy is ignored.
  - out_ready while out_valid=0 has no effect.
  - in_valid in HOLD/IDLE is not accepted.
- cfg_cols=0: start → FLUSH → IDLE with done the next cycle. No beats are accepted.
- col_cnt is CW bits and never wraps within a frame, because cols ≤ 2^CW-1.

Decomposition:
- Shared package pool_pkg:
  - state encoding (IDLE, RUN, HOLD, FLUSH);
  - ctl bit positions (CTL_WRITE=3, CTL_UP=2, CTL_CUR=1, CTL_LOW=0);
  - ctl word constants (CTL_K2_ACTIVE=4'b1011, CTL_K3_ACTIVE=4'b1111, CTL_IDLE=4'b0000).
- One sub-module: pool_ctl_mask. It is combinational and generates the D-unit active mask and the 4*D ctl vector from k and an enable.

Test Plan:
- Reset: RSTn low mid-RUN at col 3 → all outputs 0 asynchronously, busy=0. After release, start with k=2, cols=4 runs normally.
- D=4, k=2, cols=4, in_valid held high, out_ready high:
  - beats 1,2 → ctl=16'b0000_1011_0000_1011, acc_first on beat 1 only;
  - out_valid one cycle after beat 2; same again for beats 3,4;
  - then done pulse; exactly 4 beats accepted.
- D=4, k=3, cols=7:
  - beats → ctl=16'b0000_0000_1111_0000;
  - two windows produce out_valid twice;
  - column 7 accepted in FLUSH with ctl=0;
  - done after it.
- Backpressure: k=2, out_ready held low 5 cycles → out_valid stays 1, in_ready=0, ctl=0 throughout. Release → next column accepted the following cycle.
- in_valid gaps: k=2, in_valid toggling 1,0,1 → ctl nonzero only on the valid cycles; win_col advances only on accepts.
- Edge config: cfg_k=0 behaves as k=2. cfg_cols=1 with k=2 → one FLUSH beat with ctl=0, no out_valid, then done. start during RUN → ignored, latched cols unchanged.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling-column sequencer: FSM encoding and
// the per-unit control word layout {write, useUpper, useCurrent, useLower}.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Bit positions inside one unit's 4-bit control word.
  localparam int CTL_WRITE = 3;
  localparam int CTL_UP    = 2;
  localparam int CTL_CUR   = 1;
  localparam int CTL_LOW   = 0;

  // k=2 windows pair a unit with the row below it; k=3 also pulls the row above.
  localparam logic [3:0] CTL_K2_ACTIVE = 4'((1 << CTL_WRITE) | (1 << CTL_CUR) | (1 << CTL_LOW));
  localparam logic [3:0] CTL_K3_ACTIVE = 4'((1 << CTL_WRITE) | (1 << CTL_UP) |
                                            (1 << CTL_CUR) | (1 << CTL_LOW));
  localparam logic [3:0] CTL_IDLE      = 4'b0000;

endpackage

// File: rtl/pool_ctl_mask.sv
// Combinational control-word generator: decides which ALU units own a
// vertical window for the current k and expands that into the ctl bus.
module pool_ctl_mask
  import pool_pkg::*;
#(
  parameter int D = 4
) (
  input  logic           i_k3,
  input  logic           i_en,
  output logic [4*D-1:0] o_ctl
);

  logic [D-1:0] w_mask;

  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_unit
      // A unit is a window centre only if the row(s) it reads exist below it.
      localparam bit ACT_K2 = ((gi % 2) == 0) && ((gi + 1) < D);
      localparam bit ACT_K3 = ((gi % 3) == 1) && ((gi + 1) < D);

      assign w_mask[gi]       = i_en && (i_k3 ? ACT_K3 : ACT_K2);
      assign o_ctl[4*gi +: 4] = w_mask[gi] ? (i_k3 ? CTL_K3_ACTIVE : CTL_K2_ACTIVE)
                                           : CTL_IDLE;
    end
  endgenerate

endmodule

// File: rtl/pool_ctl_seq.sv
// Max-pooling column sequencer: accepts feature-map columns, drives the ALU
// control word per accepted beat, and holds a pooled-column valid until taken.
module pool_ctl_seq
  import pool_pkg::*;
#(
  parameter int depth = 2,
  parameter int D     = 1 << depth,
  parameter int CW    = 8
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           start,
  input  logic [1:0]     cfg_k,
  input  logic [CW-1:0]  cfg_cols,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*D-1:0] ctl,
  output logic           acc_first,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_k3;
  logic [CW-1:0] r_cols;
  logic [CW-1:0] r_col_cnt;
  logic [1:0]    r_win_col;
  logic          r_done;

  logic          w_start_k3;
  logic [CW-1:0] w_start_k;
  logic [CW-1:0] w_k;
  logic [CW-1:0] w_remain;
  logic          w_win_last;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_run_beat;
  logic          w_done_next;

  // Any cfg_k other than 3 degrades to a 2-wide window.
  assign w_start_k3 = (cfg_k == 2'd3);
  assign w_start_k  = w_start_k3 ? CW'(3) : CW'(2);
  assign w_k        = r_k3 ? CW'(3) : CW'(2);
  assign w_remain   = r_cols - r_col_cnt;
  assign w_win_last = r_k3 ? (r_win_col == 2'd2) : (r_win_col == 2'd1);

  // FLUSH stops accepting once the frame's column count is reached.
  assign w_in_ready = (r_state == RUN) || ((r_state == FLUSH) && (r_col_cnt != r_cols));
  assign w_accept   = in_valid && w_in_ready;
  assign w_run_beat = w_accept && (r_state == RUN);

  // Next-state selection and the end-of-frame pulse request.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (cfg_cols < w_start_k) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (w_run_beat && w_win_last) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (r_col_cnt == r_cols) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else if (w_remain < w_k) begin
            w_state_next = FLUSH;
          end else begin
            w_state_next = RUN;
          end
        end
      end
      FLUSH: begin
        // Leave on the last trailing beat, or at once if nothing is left.
        if ((r_col_cnt == r_cols) || (w_accept && ((r_col_cnt + CW'(1)) == r_cols))) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, latched frame configuration and column/window counters.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= IDLE;
      r_k3      <= 1'b0;
      r_cols    <= '0;
      r_col_cnt <= '0;
      r_win_col <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      if ((r_state == IDLE) && start) begin
        r_k3      <= w_start_k3;
        r_cols    <= cfg_cols;
        r_col_cnt <= '0;
        r_win_col <= '0;
      end else begin
        if (w_accept) begin
          r_col_cnt <= r_col_cnt + CW'(1);
        end
        if (w_run_beat) begin
          r_win_col <= w_win_last ? 2'd0 : (r_win_col + 2'd1);
        end
      end
    end
  end

  pool_ctl_mask #(
    .D (D)
  ) u_mask (
    .i_k3  (r_k3),
    .i_en  (w_run_beat),
    .o_ctl (ctl)
  );

  assign in_ready  = w_in_ready;
  assign acc_first = w_run_beat && (r_win_col == 2'd0);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule
